// File: rtl/kmeans_pkg.sv
// Shared types and constants for the k-means frame scheduler and its delta unit.
package kmeans_pkg;
    localparam int X_W         = 11;
    localparam int Y_W         = 10;
    localparam int D_W         = 12;
    localparam int MAX_PLAYERS = 4;

    localparam logic [1:0] ONE_PLAYER    = 2'd0;
    localparam logic [1:0] TWO_PLAYERS   = 2'd1;
    localparam logic [1:0] THREE_PLAYERS = 2'd2;
    localparam logic [1:0] FOUR_PLAYERS  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_ARM,
        ST_ACCUM,
        ST_TAB,
        ST_WAIT,
        ST_UPDATE
    } state_t;

    // The sum of the two distances is at most 2047+1023, so 12 bits cannot overflow.
    function automatic logic [D_W-1:0] manhattan(input logic [X_W-1:0] xa, input logic [X_W-1:0] xb,
                                                 input logic [Y_W-1:0] ya, input logic [Y_W-1:0] yb);
        logic [X_W-1:0] dx;
        logic [Y_W-1:0] dy;
        dx = (xa >= xb) ? xa - xb : xb - xa;
        dy = (ya >= yb) ? ya - yb : yb - ya;
        return D_W'(dx) + D_W'(dy);
    endfunction
endpackage

// File: rtl/kmeans_centroid_delta.sv
// Per-player Manhattan move between new and published centroids.
// Flags stability only when every active player moved at most CONV_THRESH.
module kmeans_centroid_delta
    import kmeans_pkg::*;
#(
    parameter int CONV_THRESH = 8
) (
    input  logic [MAX_PLAYERS-1:0][X_W-1:0] new_x,
    input  logic [MAX_PLAYERS-1:0][Y_W-1:0] new_y,
    input  logic [MAX_PLAYERS-1:0][X_W-1:0] old_x,
    input  logic [MAX_PLAYERS-1:0][Y_W-1:0] old_y,
    input  logic [1:0]                      players,
    output logic                            all_stable
);
    logic [MAX_PLAYERS-1:0][D_W-1:0] delta;

    always_comb begin
        delta      = '0;
        all_stable = 1'b1;
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            delta[i] = manhattan(new_x[i], old_x[i], new_y[i], old_y[i]);
            if (i <= int'(players) && delta[i] > D_W'(CONV_THRESH)) begin
                all_stable = 1'b0;
            end
        end
    end
endmodule

// File: rtl/kmeans_frame_scheduler.sv
// Frame-level controller for the k-means player tracker: seeds the datapath,
// gates one frame of pixels into it, collects centroids and tracks convergence.
module kmeans_frame_scheduler
    import kmeans_pkg::*;
#(
    parameter int SEED_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CONV_THRESH    = 8,
    parameter int STABLE_FRAMES  = 3
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            enable_in,
    input  logic [1:0]                      num_players_in,
    input  logic                            frame_start_in,
    input  logic                            frame_end_in,
    input  logic                            pixel_valid_in,
    output logic                            km_rst_out,
    output logic                            km_valid_out,
    output logic                            km_tabulate_out,
    output logic [1:0]                      km_players_out,
    input  logic [MAX_PLAYERS-1:0][X_W-1:0] km_x_in,
    input  logic [MAX_PLAYERS-1:0][Y_W-1:0] km_y_in,
    input  logic                            km_valid_in,
    output logic [MAX_PLAYERS-1:0][X_W-1:0] pos_x_out,
    output logic [MAX_PLAYERS-1:0][Y_W-1:0] pos_y_out,
    output logic                            pos_valid_out,
    output logic                            locked_out,
    output logic                            timeout_out
);
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int STAB_W = $clog2(STABLE_FRAMES + 1);

    state_t                          state, state_next;
    logic [CNT_W-1:0]                cnt;
    logic [STAB_W-1:0]               stable_cnt, stable_next;
    logic                            players_seen;
    logic                            first_after_seed;
    logic                            players_changed;
    logic                            frame_error;
    logic                            all_stable;
    logic [MAX_PLAYERS-1:0][X_W-1:0] cent_x;
    logic [MAX_PLAYERS-1:0][Y_W-1:0] cent_y;

    // Nothing latched since reset is treated as a change so the tracker is always reseeded.
    assign players_changed = !players_seen || (num_players_in != km_players_out);
    assign frame_error     = enable_in && state == ST_ACCUM && frame_start_in && !frame_end_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable_in) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_next = ST_SEED;
                ST_SEED:   if (cnt == '0) state_next = ST_ARM;
                ST_ARM:    if (frame_start_in) state_next = players_changed ? ST_SEED : ST_ACCUM;
                ST_ACCUM: begin
                    if (frame_end_in)        state_next = ST_TAB;
                    else if (frame_start_in) state_next = ST_SEED;
                end
                ST_TAB:    state_next = ST_WAIT;
                ST_WAIT: begin
                    if (km_valid_in)     state_next = ST_UPDATE;
                    else if (cnt == '0)  state_next = ST_SEED;
                end
                ST_UPDATE: state_next = ST_ARM;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        km_rst_out      = enable_in && state == ST_SEED;
        km_tabulate_out = enable_in && state == ST_TAB;
        km_valid_out    = enable_in && pixel_valid_in &&
                          (state == ST_ACCUM || (state == ST_ARM && frame_start_in && !players_changed));
        timeout_out     = enable_in && state == ST_WAIT && !km_valid_in && cnt == '0;
    end

    // One down-counter serves both the seed hold and the WAIT timeout.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else if (state_next != state) begin
            case (state_next)
                ST_SEED: cnt <= CNT_W'(SEED_CYCLES - 1);
                ST_WAIT: cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
                default: cnt <= '0;
            endcase
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    kmeans_centroid_delta #(.CONV_THRESH(CONV_THRESH)) u_delta (
        .new_x      (cent_x),
        .new_y      (cent_y),
        .old_x      (pos_x_out),
        .old_y      (pos_y_out),
        .players    (km_players_out),
        .all_stable (all_stable)
    );

    always_comb begin
        stable_next = stable_cnt;
        if (first_after_seed || !all_stable)             stable_next = '0;
        else if (stable_cnt != STAB_W'(STABLE_FRAMES))   stable_next = stable_cnt + 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            km_players_out   <= '0;
            players_seen     <= 1'b0;
            first_after_seed <= 1'b1;
            cent_x           <= '0;
            cent_y           <= '0;
            pos_x_out        <= '0;
            pos_y_out        <= '0;
            pos_valid_out    <= 1'b0;
            stable_cnt       <= '0;
            locked_out       <= 1'b0;
        end else begin
            pos_valid_out <= enable_in && state == ST_UPDATE;
            if (enable_in && state == ST_ARM && frame_start_in) begin
                km_players_out <= num_players_in;
                players_seen   <= 1'b1;
            end
            if (enable_in && state == ST_WAIT && km_valid_in) begin
                cent_x <= km_x_in;
                cent_y <= km_y_in;
            end
            if (state == ST_SEED) first_after_seed <= 1'b1;
            if (!enable_in || timeout_out || frame_error) begin
                stable_cnt <= '0;
                locked_out <= 1'b0;
            end else if (state == ST_UPDATE) begin
                first_after_seed <= 1'b0;
                stable_cnt       <= stable_next;
                locked_out       <= stable_next == STAB_W'(STABLE_FRAMES);
                for (int i = 0; i < MAX_PLAYERS; i++) begin
                    pos_x_out[i] <= (i <= int'(km_players_out)) ? cent_x[i] : '0;
                    pos_y_out[i] <= (i <= int'(km_players_out)) ? cent_y[i] : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_kmeans_frame_scheduler.sv
// Directed checks of the frame scheduler: seeding, gating, convergence, timeout and aborts.
module tb_kmeans_frame_scheduler;
    import kmeans_pkg::*;

    logic                            clk_in = 1'b0;
    logic                            rst_in;
    logic                            enable_in;
    logic [1:0]                      num_players_in;
    logic                            frame_start_in;
    logic                            frame_end_in;
    logic                            pixel_valid_in;
    logic                            km_rst_out;
    logic                            km_valid_out;
    logic                            km_tabulate_out;
    logic [1:0]                      km_players_out;
    logic [MAX_PLAYERS-1:0][X_W-1:0] km_x_in;
    logic [MAX_PLAYERS-1:0][Y_W-1:0] km_y_in;
    logic                            km_valid_in;
    logic [MAX_PLAYERS-1:0][X_W-1:0] pos_x_out;
    logic [MAX_PLAYERS-1:0][Y_W-1:0] pos_y_out;
    logic                            pos_valid_out;
    logic                            locked_out;
    logic                            timeout_out;

    int total = 0;
    int bad   = 0;

    kmeans_frame_scheduler dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .num_players_in  (num_players_in),
        .frame_start_in  (frame_start_in),
        .frame_end_in    (frame_end_in),
        .pixel_valid_in  (pixel_valid_in),
        .km_rst_out      (km_rst_out),
        .km_valid_out    (km_valid_out),
        .km_tabulate_out (km_tabulate_out),
        .km_players_out  (km_players_out),
        .km_x_in         (km_x_in),
        .km_y_in         (km_y_in),
        .km_valid_in     (km_valid_in),
        .pos_x_out       (pos_x_out),
        .pos_y_out       (pos_y_out),
        .pos_valid_out   (pos_valid_out),
        .locked_out      (locked_out),
        .timeout_out     (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Called in ARM; returns in the first WAIT cycle with the gated-pixel count and tabulate samples.
    task automatic run_frame(input int n, output int passed, output int tab_a, output int tab_b);
        passed = 0;
        for (int i = 0; i < n; i++) begin
            frame_start_in = (i == 0);
            frame_end_in   = (i == n - 1);
            pixel_valid_in = 1'b1;
            #1;
            passed += int'(km_valid_out);
            tick();
        end
        frame_start_in = 1'b0;
        frame_end_in   = 1'b0;
        #1;
        tab_a  = int'(km_tabulate_out);
        passed += int'(km_valid_out);
        tick();
        tab_b  = int'(km_tabulate_out);
        passed += int'(km_valid_out);
        pixel_valid_in = 1'b0;
    endtask

    // Called in WAIT; returns in ARM with pos_valid samples from the publish cycle and the one after.
    task automatic deliver(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int x3, input int y3,
                           output int pv_a, output int pv_b);
        km_x_in[0] = 11'(x0); km_y_in[0] = 10'(y0);
        km_x_in[1] = 11'(x1); km_y_in[1] = 10'(y1);
        km_x_in[2] = 11'(x2); km_y_in[2] = 10'(y2);
        km_x_in[3] = 11'(x3); km_y_in[3] = 10'(y3);
        km_valid_in = 1'b1;
        tick();
        km_valid_in = 1'b0;
        tick();
        pv_a = int'(pos_valid_out);
        tick();
        pv_b = int'(pos_valid_out);
    endtask

    initial begin
        int cnt, pas, ta, tb, pva, pvb, k;
        int mx[3] = '{317, 317, 309};
        int my[3] = '{60, 68, 68};
        int ml[3] = '{0, 0, 1};

        rst_in = 1'b1; enable_in = 1'b0; num_players_in = 2'd1;
        frame_start_in = 1'b0; frame_end_in = 1'b0; pixel_valid_in = 1'b0;
        km_x_in = '0; km_y_in = '0; km_valid_in = 1'b0;
        repeat (3) tick();
        chk("rst_km_rst", int'(km_rst_out), 0);
        chk("rst_pos_valid", int'(pos_valid_out), 0);
        chk("rst_locked", int'(locked_out), 0);
        chk("rst_players", int'(km_players_out), 0);
        rst_in = 1'b0;
        tick();

        enable_in = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += int'(km_rst_out);
        end
        chk("seed_len", cnt, 4);

        // First start after reset always reseeds.
        frame_start_in = 1'b1; pixel_valid_in = 1'b1;
        #1;
        chk("first_start_gated", int'(km_valid_out), 0);
        tick();
        frame_start_in = 1'b0; pixel_valid_in = 1'b0;
        chk("latch_players", int'(km_players_out), 1);
        chk("reseed_after_latch", int'(km_rst_out), 1);
        repeat (6) tick();

        run_frame(640, pas, ta, tb);
        chk("pixels_640", pas, 640);
        chk("tab_pulse", ta, 1);
        chk("tab_single", tb, 0);
        deliver(100, 50, 300, 60, 55, 44, 66, 33, pva, pvb);
        chk("pos_valid_1", pva, 1);
        chk("pos_valid_off", pvb, 0);
        chk("pos_x0", int'(pos_x_out[0]), 100);
        chk("pos_y1", int'(pos_y_out[1]), 60);
        chk("pos_x2_masked", int'(pos_x_out[2]), 0);
        chk("lock_f1", int'(locked_out), 0);

        for (int f = 2; f <= 4; f++) begin
            run_frame(8, pas, ta, tb);
            deliver(100, 50, 300, 60, 0, 0, 0, 0, pva, pvb);
            chk("conv_pos_valid", pva, 1);
            chk("conv_locked", int'(locked_out), (f == 4) ? 1 : 0);
        end

        run_frame(8, pas, ta, tb);
        deliver(100, 50, 309, 60, 0, 0, 0, 0, pva, pvb);
        chk("move9_unlock", int'(locked_out), 0);
        for (int f = 0; f < 3; f++) begin
            run_frame(8, pas, ta, tb);
            deliver(100, 50, mx[f], my[f], 0, 0, 0, 0, pva, pvb);
            chk("move8_locked", int'(locked_out), ml[f]);
        end

        run_frame(8, pas, ta, tb);
        k = 1;
        while (!timeout_out && k < 5000) begin
            tick();
            k++;
        end
        chk("timeout_cycle", k, 4096);
        chk("locked_before_timeout", int'(locked_out), 1);
        tick();
        chk("timeout_unlock", int'(locked_out), 0);
        chk("timeout_reseed", int'(km_rst_out), 1);
        chk("timeout_single", int'(timeout_out), 0);
        repeat (5) tick();

        // Player count changes in the middle of a frame; the latch waits for the next ARM.
        frame_start_in = 1'b1; pixel_valid_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        num_players_in = 2'd2;
        repeat (4) tick();
        chk("players_hold_accum", int'(km_players_out), 1);
        frame_end_in = 1'b1;
        tick();
        frame_end_in = 1'b0; pixel_valid_in = 1'b0;
        tick();
        deliver(100, 50, 309, 68, 500, 400, 0, 0, pva, pvb);
        chk("old_count_masks_p2", int'(pos_x_out[2]), 0);
        frame_start_in = 1'b1; pixel_valid_in = 1'b1;
        #1;
        chk("count_change_gated", int'(km_valid_out), 0);
        tick();
        frame_start_in = 1'b0; pixel_valid_in = 1'b0;
        chk("players_3", int'(km_players_out), 2);
        chk("count_change_seed", int'(km_rst_out), 1);
        repeat (6) tick();
        run_frame(8, pas, ta, tb);
        deliver(10, 20, 30, 40, 50, 60, 700, 600, pva, pvb);
        chk("pos_x2_active", int'(pos_x_out[2]), 50);
        chk("pos_x3_unused", int'(pos_x_out[3]), 0);
        chk("pos_y3_unused", int'(pos_y_out[3]), 0);
        chk("lock_after_seed", int'(locked_out), 0);

        km_x_in = '1; km_valid_in = 1'b1;
        tick();
        tick();
        km_valid_in = 1'b0;
        chk("valid_in_ignored_pv", int'(pos_valid_out), 0);
        chk("valid_in_ignored_pos", int'(pos_x_out[0]), 10);

        frame_start_in = 1'b1; pixel_valid_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        repeat (3) tick();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0; pixel_valid_in = 1'b0;
        chk("frame_err_seed", int'(km_rst_out), 1);
        repeat (6) tick();

        frame_start_in = 1'b1; pixel_valid_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        tick();
        chk("accum_pass", int'(km_valid_out), 1);
        enable_in = 1'b0;
        tick();
        chk("disable_valid", int'(km_valid_out), 0);
        chk("disable_rst", int'(km_rst_out), 0);
        chk("disable_pos_hold", int'(pos_x_out[0]), 10);
        enable_in = 1'b1;
        tick();
        chk("reenable_seed", int'(km_rst_out), 1);
        repeat (6) tick();

        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        repeat (2) tick();
        rst_in = 1'b1;
        #1;
        chk("async_rst_valid", int'(km_valid_out), 0);
        frame_end_in = 1'b1;
        tick();
        frame_end_in = 1'b0;
        chk("async_rst_no_tab", int'(km_tabulate_out), 0);
        rst_in = 1'b0; pixel_valid_in = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
